// File: rtl/alinx_key_entropy.sv
// Synchronises and debounces the four Alinx push-buttons and emits stamped key events.
// Optional feature: define ALINX_KEY_RELEASE_EVENT_EN to also emit release events.
module alinx_key_entropy #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int STAMP_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   key1,
  input  logic                   key2,
  input  logic                   key3,
  input  logic                   key4,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [1:0]             event_key,
  output logic                   event_press,
  output logic [STAMP_WIDTH-1:0] event_stamp,
  output logic [3:0]             key_state,
  output logic                   overflow
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       RELEASED = {4{KEY_ACTIVE_LOW}};
`ifdef ALINX_KEY_RELEASE_EVENT_EN
  localparam int FLAG_SHIFT = 1;
`else
  localparam int FLAG_SHIFT = 0;
`endif
  localparam int NUM_FLAGS = 4 << FLAG_SHIFT;

  logic [3:0]             sync1_q, sync1_d;
  logic [3:0]             sync2_q, sync2_d;
  logic [3:0]             stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q [4];
  logic [CNT_W-1:0]       cnt_d [4];
  logic [STAMP_WIDTH-1:0] stamp_q, stamp_d;
  logic [NUM_FLAGS-1:0]   pend_q, pend_d;
  logic [STAMP_WIDTH-1:0] pstamp_q [NUM_FLAGS];
  logic [STAMP_WIDTH-1:0] pstamp_d [NUM_FLAGS];
  logic                   valid_q, valid_d;
  logic [1:0]             key_q, key_d;
  logic                   press_q, press_d;
  logic [STAMP_WIDTH-1:0] estamp_q, estamp_d;
  logic                   ovf_q, ovf_d;
  logic [3:0]             sample;
  logic [NUM_FLAGS-1:0]   arrive;
  logic                   loadable;
  logic                   found;

  // Flag layout: one flag per key, or press/release pairs per key (press at the even slot).
  always_comb begin
    sync1_d  = {key4, key3, key2, key1};
    sync2_d  = sync1_q;
    sample   = sync2_q ^ RELEASED;
    stamp_d  = stamp_q + 1'b1;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    arrive   = '0;
    for (int k = 0; k < 4; k++) begin
      if (sample[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        stable_d[k] = sample[k];
        cnt_d[k]    = '0;
`ifdef ALINX_KEY_RELEASE_EVENT_EN
        if (sample[k]) arrive[2*k] = 1'b1;
        else           arrive[2*k+1] = 1'b1;
`else
        arrive[k] = sample[k];
`endif
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // A flag freed by this cycle's unload may be re-armed by a same-cycle transition.
  always_comb begin
    loadable = ~valid_q | event_ready;
    found    = 1'b0;
    valid_d  = valid_q;
    key_d    = key_q;
    press_d  = press_q;
    estamp_d = estamp_q;
    pend_d   = pend_q;
    pstamp_d = pstamp_q;
    ovf_d    = ovf_q;
    if (loadable) begin
      valid_d = 1'b0;
      for (int f = 0; f < NUM_FLAGS; f++) begin
        if (pend_q[f] && !found) begin
          found     = 1'b1;
          valid_d   = 1'b1;
          key_d     = 2'(f >> FLAG_SHIFT);
          press_d   = (FLAG_SHIFT == 0) || ((f % 2) == 0);
          estamp_d  = pstamp_q[f];
          pend_d[f] = 1'b0;
        end
      end
    end
    for (int f = 0; f < NUM_FLAGS; f++) begin
      if (arrive[f]) begin
        if (pend_d[f]) begin
          ovf_d = 1'b1;
        end else begin
          pend_d[f]   = 1'b1;
          pstamp_d[f] = stamp_d;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      sync1_q  <= RELEASED;
      sync2_q  <= RELEASED;
      stable_q <= '0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      stamp_q  <= '0;
      pend_q   <= '0;
      for (int f = 0; f < NUM_FLAGS; f++) pstamp_q[f] <= '0;
      valid_q  <= 1'b0;
      key_q    <= '0;
      press_q  <= 1'b0;
      estamp_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      stamp_q  <= stamp_d;
      pend_q   <= pend_d;
      pstamp_q <= pstamp_d;
      valid_q  <= valid_d;
      key_q    <= key_d;
      press_q  <= press_d;
      estamp_q <= estamp_d;
      ovf_q    <= ovf_d;
    end
  end

  assign event_valid = valid_q;
  assign event_key   = key_q;
  assign event_press = press_q;
  assign event_stamp = estamp_q;
  assign key_state   = stable_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_alinx_key_entropy.sv
// Self-checking bench for alinx_key_entropy: directed scenarios plus random key activity,
// compared every cycle against a pin-history reference model.
module tb_alinx_key_entropy;

  localparam int D  = 8;
  localparam int SW = 8;
`ifdef ALINX_KEY_RELEASE_EVENT_EN
  localparam int NF = 8;
`else
  localparam int NF = 4;
`endif

  logic          clock = 1'b0;
  logic          clear;
  logic          key1, key2, key3, key4;
  logic          event_ready;
  logic          event_valid;
  logic [1:0]    event_key;
  logic          event_press;
  logic [SW-1:0] event_stamp;
  logic [3:0]    key_state;
  logic          overflow;

  alinx_key_entropy #(
    .DEBOUNCE_CYCLES(D),
    .KEY_ACTIVE_LOW(1'b1),
    .STAMP_WIDTH(SW)
  ) dut (
    .clock(clock),
    .clear(clear),
    .key1(key1),
    .key2(key2),
    .key3(key3),
    .key4(key4),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_key(event_key),
    .event_press(event_press),
    .event_stamp(event_stamp),
    .key_state(key_state),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: pressed-level history per key, debounced state, pending flags, output slot.
  bit         hq [4][$];
  bit [3:0]   mstate;
  bit [NF-1:0] mpend;
  int         mpst [NF];
  bit         mvalid;
  int         mkey;
  bit         mpress;
  int         mstamp;
  bit         movf;
  int         mcyc = 0;

  function automatic void modelReset();
    for (int k = 0; k < 4; k++) begin
      hq[k].delete();
      hq[k].push_back(1'b0);
      hq[k].push_back(1'b0);
    end
    mstate = '0;
    mpend  = '0;
    for (int f = 0; f < NF; f++) mpst[f] = 0;
    mvalid = 1'b0;
    mkey   = 0;
    mpress = 1'b0;
    mstamp = 0;
    movf   = 1'b0;
    mcyc   = 0;
  endfunction

  // A key's level flips once its last D synchronised samples all disagree with it.
  function automatic void modelStep();
    bit [3:0]    pin;
    bit [NF-1:0] arrive;
    bit          all;
    int          n;
    int          sel;
    if (clear === 1'b1) begin
      modelReset();
      return;
    end
    mcyc++;
    pin    = ~{key4, key3, key2, key1};
    arrive = '0;
    for (int k = 0; k < 4; k++) begin
      hq[k].push_back(pin[k]);
      if (hq[k].size() > 32) void'(hq[k].pop_front());
      n = hq[k].size();
      if (n >= D + 2) begin
        all = 1'b1;
        for (int j = 0; j < D; j++) if (hq[k][n-3-j] == mstate[k]) all = 1'b0;
        if (all) begin
          mstate[k] = ~mstate[k];
`ifdef ALINX_KEY_RELEASE_EVENT_EN
          if (mstate[k]) arrive[2*k] = 1'b1;
          else           arrive[2*k+1] = 1'b1;
`else
          if (mstate[k]) arrive[k] = 1'b1;
`endif
        end
      end
    end
    if (!mvalid || event_ready === 1'b1) begin
      sel = -1;
      for (int f = 0; f < NF; f++) if (mpend[f] && sel < 0) sel = f;
      mvalid = (sel >= 0);
      if (sel >= 0) begin
        mpend[sel] = 1'b0;
        mstamp     = mpst[sel];
`ifdef ALINX_KEY_RELEASE_EVENT_EN
        mkey   = sel / 2;
        mpress = ((sel % 2) == 0);
`else
        mkey   = sel;
        mpress = 1'b1;
`endif
      end
    end
    for (int f = 0; f < NF; f++) begin
      if (arrive[f]) begin
        if (mpend[f]) movf = 1'b1;
        else begin
          mpend[f] = 1'b1;
          mpst[f]  = mcyc % 256;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, mcyc);
    end
  endtask

  task automatic checkOutput();
    check("event_valid", 32'(event_valid), 32'(mvalid));
    check("event_key",   32'(event_key),   32'(mkey));
    check("event_press", 32'(event_press), 32'(mpress));
    check("event_stamp", 32'(event_stamp), 32'(mstamp));
    check("key_state",   32'(key_state),   32'(mstate));
    check("overflow",    32'(overflow),    32'(movf));
  endtask

  task automatic applyStimulus(input logic [3:0] pressed, input logic rdy);
    key1        = ~pressed[0];
    key2        = ~pressed[1];
    key3        = ~pressed[2];
    key4        = ~pressed[3];
    event_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    @(negedge clock);
    checkOutput();
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic waitCycle(input int target);
    for (int i = 0; i < 2000 && mcyc < target; i++) tick();
    check("wait_cycle_reached", 32'(mcyc), 32'(target));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0;
    int p3;
    int quietEvents;
    int holdEvents;
    int wrapAt;
    logic [3:0] rp;

    // Reset and idle outputs
    clear = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    tick();
    tick();
    clear = 1'b0;
    check("reset_valid", 32'(event_valid), 32'd0);
    check("reset_key_state", 32'(key_state), 32'd0);
    check("reset_stamp", 32'(event_stamp), 32'd0);

    // key2 held from cycle 10: key_state at 20, event at 21 stamped 20
    applyStimulus(4'b0000, 1'b1);
    waitCycle(10);
    applyStimulus(4'b0010, 1'b1);
    waitCycle(19);
    check("key2_state_early", 32'(key_state), 32'd0);
    tick();
    check("key2_state", 32'(key_state), 32'b0010);
    check("key2_valid_not_yet", 32'(event_valid), 32'd0);
    tick();
    check("key2_valid", 32'(event_valid), 32'd1);
    check("key2_key", 32'(event_key), 32'd1);
    check("key2_press", 32'(event_press), 32'd1);
    check("key2_stamp", 32'(event_stamp), 32'd20);
    tick();
    check("key2_single_cycle", 32'(event_valid), 32'd0);
    applyStimulus(4'b0000, 1'b1);
    tickN(14);

    // key1 bounces with 3-cycle runs, then held pressed
    quietEvents = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus({3'b000, ((i / 3) % 2) == 0}, 1'b1);
      tick();
      if (event_valid === 1'b1) quietEvents++;
    end
    holdEvents = 0;
    applyStimulus(4'b0001, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (event_valid === 1'b1 && event_key === 2'd0) holdEvents++;
    end
    check("bounce_quiet", 32'(quietEvents), 32'd0);
    check("bounce_one_event", 32'(holdEvents), 32'd1);
    applyStimulus(4'b0000, 1'b1);
    tickN(14);

    // key1 and key4 together while stalled
    applyStimulus(4'b1001, 1'b0);
    p0 = mcyc;
    waitCycle(p0 + 11);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(event_valid), 32'd1);
      check("stall_key", 32'(event_key), 32'd0);
      check("stall_stamp", 32'(event_stamp), 32'((p0 + 10) % 256));
      tick();
    end
    applyStimulus(4'b1001, 1'b1);
    tick();
    check("second_key", 32'(event_key), 32'd3);
    check("second_stamp", 32'(event_stamp), 32'((p0 + 10) % 256));
    applyStimulus(4'b0000, 1'b1);
    tickN(14);

    // Overflow: key3 press/release/re-press while the output is stalled on key1
    applyStimulus(4'b0001, 1'b0);
    tickN(12);
    applyStimulus(4'b0101, 1'b0);
    p3 = mcyc;
    tickN(12);
    applyStimulus(4'b0001, 1'b0);
    tickN(12);
    applyStimulus(4'b0101, 1'b0);
    tickN(12);
    check("overflow_set", 32'(overflow), 32'd1);
    applyStimulus(4'b0101, 1'b1);
    tick();
    check("ovf_event_key", 32'(event_key), 32'd2);
    check("ovf_event_press", 32'(event_press), 32'd1);
    check("ovf_first_stamp", 32'(event_stamp), 32'((p3 + 10) % 256));
    tickN(20);
    check("overflow_sticky", 32'(overflow), 32'd1);
    applyStimulus(4'b0000, 1'b1);
    tickN(14);

    // clear while an event is stalled and key2 is held
    applyStimulus(4'b0010, 1'b0);
    tickN(12);
    check("pre_clear_valid", 32'(event_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_valid", 32'(event_valid), 32'd0);
    check("clear_key_state", 32'(key_state), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);
    applyStimulus(4'b0010, 1'b1);
    waitCycle(10);
    check("post_clear_state", 32'(key_state), 32'b0010);
    tick();
    check("post_clear_valid", 32'(event_valid), 32'd1);
    check("post_clear_key", 32'(event_key), 32'd1);
    check("post_clear_stamp", 32'(event_stamp), 32'd10);
    applyStimulus(4'b0000, 1'b1);
    tickN(14);

    // Stamp wrap: transition lands on a multiple of 256
    wrapAt = ((mcyc + 12) / 256 + 1) * 256;
    waitCycle(wrapAt - 10);
    applyStimulus(4'b1000, 1'b1);
    waitCycle(wrapAt + 1);
    check("wrap_valid", 32'(event_valid), 32'd1);
    check("wrap_key", 32'(event_key), 32'd3);
    check("wrap_stamp", 32'(event_stamp), 32'd0);
    tickN(3);

    // Random key activity and ready pattern
    rp = 4'b1000;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 9) == 0) rp[k] = ~rp[k];
      applyStimulus(rp, $urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
